board_commit_judge: RTL and testbench
=====================================

# board_commit_judge

Game-board register and referee for the tic-tac-toe datapath. It sits directly downstream of the move-selection stages (the AI position pickers and the player input path). It accepts one cell address plus player code per handshake, rejects illegal moves, and writes legal ones into the 18-bit board. It then scans the eight winning lines sequentially to publish the game result, and its `gBoard` output feeds back into the AI stages.

## Interface
- No parameters; the board size is fixed at 9 cells, 2 bits each.
- Cell encoding: empty 00, player1 11, player2 10. Cell i occupies `gBoard[2i+1:2i]`; rows are cells 0-2, 3-5, 6-8.
- Result encoding: player1 11, player2 10, tie 01, noWin 00.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous new-game clear.
- `move_valid`  in  1  move request; held by upstream until accepted.
- `move_addr`  in  4  target cell 0-8; 9-15 (incl. 4'b1111 "bad address") illegal.
- `move_player`  in  2  11 or 10; any other value illegal.
- `move_ready`  out  1  combinational; high only in IDLE.
- `move_ack`  out  1  one-cycle pulse: move written.
- `move_err`  out  1  one-cycle pulse: move rejected, board unchanged.
- `gBoard`  out  18  registered board state.
- `move_count`  out  4  legal moves written since clear, 0-9.
- `result`  out  2  game result code.
- `result_valid`  out  1  high while in OVER (game finished).

## Operation
- States: IDLE, CHECK, OVER.
- Handshake: a transfer occurs on a rising edge with `move_valid & move_ready`. `move_valid` while not ready is ignored; no ack, no err.
- Legality at transfer: `move_addr <= 8`, `move_player` in {11,10}, and target cell == 00.
- Illegal transfer: `move_err`=1 for the following cycle; state stays IDLE; `gBoard`, `move_count`, `result` unchanged.
- Legal transfer: cell written with `move_player`, `move_count`+1, player latched, `move_ack`=1 for the following cycle, line counter := 0, go to CHECK.
- CHECK: each cycle tests line[cnt] for three cells all equal to the latched player. Line order:
  - 0-2: rows (0,1,2), (3,4,5), (6,7,8)
  - 3-5: columns (0,3,6), (1,4,7), (2,5,8)
  - 6: diagonal (0,4,8)
  - 7: diagonal (2,4,6)
- Hit: `result` := latched player, go to OVER (early exit; remaining lines are skipped).
- cnt==7 with no hit: if all nine cells are nonzero (all bits `2i+1` set), `result` := 01 and go to OVER; otherwise go to IDLE with `result` 00. Otherwise cnt+1.
- Only the mover's lines are tested; the opponent cannot win on this move.
- OVER: terminal until `clear` or reset. `move_ready`=0.
- `clear`: from any state, next edge forces IDLE, `gBoard`=0, `move_count`=0, `result`=00, cnt=0, ack/err=0.
- `clear` has priority over a simultaneous transfer; the move is dropped with no ack and no err.
- Reset (asynchronous, any state, mid-CHECK included): IDLE, `gBoard`=0, `move_count`=0, `result`=00, `result_valid`=0, `move_ack`=0, `move_err`=0, cnt=0. `move_ready`=1 follows from IDLE.

## Timing
- Transfer on edge E0: `gBoard` shows the new cell and `move_ack` is high after E0; both are visible in the same cycle.
- Win on line k: `result`/`result_valid` valid after edge E(k+1), k = 0..7. The worst case, a win on line 7, is 8 cycles.
- No win: the return to IDLE (`move_ready`=1) or tie OVER follows edge E8. Maximum move throughput is one per 9 cycles, counting the accept cycle.
- Rejected move: `move_err` after E0. `move_ready` stays high, so a new move can transfer on E1.
- `move_ack` and `move_err` are never high together.
- `result` changes only on entry to OVER, on `clear`, or on reset.

## Test plan
- Reset, then a legal move: `reset_n` low mid-run → all outputs 0, `move_ready`=1. Then move addr 4, player 11 → `gBoard`=18'h00300, `move_ack` 1 cycle, `move_count`=1, `move_ready` back high 8 cycles after the ack.
- Row win: player 11 at 0, 1, 2, with player 10 at 3, 4 interleaved. The move at 2 → `result`=11, `result_valid`=1 one cycle after the ack (line 0); further `move_valid` is ignored.
- Diagonal win on line 7: player 10 completes 2, 4, 6 → `result`=10 exactly 8 cycles after the final ack.
- Tie: fill with 0:11 1:10 2:11 3:11 4:10 5:10 6:10 7:11 8:11 → after the 9th move, `result`=01 at E8, `move_count`=9.
- Illegal moves: addr 9, addr 4'b1111, player 01, and an occupied cell → each gives one `move_err` pulse, `gBoard` unchanged, no state change.
- Clear priority: assert `clear` with a simultaneous legal transfer, and also mid-CHECK and in OVER → next cycle IDLE, `gBoard`=0, `result`=00, no ack/err.

Source files
------------

// File: rtl/board_commit_judge_if.sv
// Move handshake and board/result bus between the move-selection stages and the board referee.
interface board_commit_judge_if;
    logic        clear;
    logic        move_valid;
    logic [3:0]  move_addr;
    logic [1:0]  move_player;
    logic        move_ready;
    logic        move_ack;
    logic        move_err;
    logic [17:0] gBoard;
    logic [3:0]  move_count;
    logic [1:0]  result;
    logic        result_valid;

    modport master (
        output clear, move_valid, move_addr, move_player,
        input  move_ready, move_ack, move_err, gBoard, move_count, result, result_valid
    );

    modport slave (
        input  clear, move_valid, move_addr, move_player,
        output move_ready, move_ack, move_err, gBoard, move_count, result, result_valid
    );
endinterface

// File: rtl/board_commit_judge.sv
// Tic-tac-toe board register and referee: accepts or rejects one move per handshake,
// then scans the eight winning lines of the mover, one per cycle, to publish the result.
module board_commit_judge (
    input  logic               clk,
    input  logic               reset_n,
    board_commit_judge_if.slave bus
);
    localparam int unsigned CELL_W  = 2;
    localparam int unsigned CELLS   = 9;
    localparam int unsigned BOARD_W = CELL_W * CELLS;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned MCNT_W  = 4;

    localparam logic [1:0] RES_NOWIN = 2'b00;
    localparam logic [1:0] RES_TIE   = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_OVER  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [BOARD_W-1:0]   board_q, board_d;
    logic [MCNT_W-1:0]    count_q, count_d;
    logic [CELL_W-1:0]    result_q, result_d;
    logic [CELL_W-1:0]    player_q, player_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;

    logic [3*ADDR_W-1:0]  line_c;
    logic                 hit_c;
    logic                 full_c;
    logic                 legal_c;

    // Cell indices of winning line k, packed {a, b, c}.
    function automatic logic [3*ADDR_W-1:0] line_cells(input logic [CNT_W-1:0] k);
        case (k)
            3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
            3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
            3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
            3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
            3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
            3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
            3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
            default: line_cells = {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    // Out-of-range addresses read as empty; legality rejects them separately.
    function automatic logic [CELL_W-1:0] cell_at(input logic [BOARD_W-1:0] b,
                                                  input logic [ADDR_W-1:0]  idx);
        cell_at = 2'b00;
        for (int i = 0; i < int'(CELLS); i++) begin
            if (idx == ADDR_W'(i)) cell_at = b[CELL_W*i +: CELL_W];
        end
    endfunction

    assign line_c  = line_cells(cnt_q);
    assign hit_c   = (cell_at(board_q, line_c[11:8]) == player_q) &&
                     (cell_at(board_q, line_c[7:4])  == player_q) &&
                     (cell_at(board_q, line_c[3:0])  == player_q);
    assign full_c  = &{board_q[17], board_q[15], board_q[13], board_q[11], board_q[9],
                       board_q[7],  board_q[5],  board_q[3],  board_q[1]};
    assign legal_c = (bus.move_addr <= 4'd8) && bus.move_player[1] &&
                     (cell_at(board_q, bus.move_addr) == 2'b00);

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        count_d  = count_q;
        result_d = result_q;
        player_d = player_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;

        if (bus.clear) begin
            state_d  = S_IDLE;
            board_d  = '0;
            count_d  = '0;
            result_d = RES_NOWIN;
            cnt_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.move_valid) begin
                        if (legal_c) begin
                            for (int i = 0; i < int'(CELLS); i++) begin
                                if (bus.move_addr == ADDR_W'(i))
                                    board_d[CELL_W*i +: CELL_W] = bus.move_player;
                            end
                            count_d  = count_q + MCNT_W'(1);
                            player_d = bus.move_player;
                            ack_d    = 1'b1;
                            cnt_d    = '0;
                            state_d  = S_CHECK;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (hit_c) begin
                        result_d = player_q;
                        state_d  = S_OVER;
                    end else if (cnt_q == CNT_W'(7)) begin
                        if (full_c) begin
                            result_d = RES_TIE;
                            state_d  = S_OVER;
                        end else begin
                            state_d  = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_OVER:  state_d = S_OVER;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            board_q  <= '0;
            count_q  <= '0;
            result_q <= RES_NOWIN;
            player_q <= '0;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            count_q  <= count_d;
            result_q <= result_d;
            player_q <= player_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign bus.move_ready   = (state_q == S_IDLE);
    assign bus.move_ack     = ack_q;
    assign bus.move_err     = err_q;
    assign bus.gBoard       = board_q;
    assign bus.move_count   = count_q;
    assign bus.result       = result_q;
    assign bus.result_valid = (state_q == S_OVER);
endmodule

// File: tb/tb_board_commit_judge.sv
// Directed vector bench for board_commit_judge: move table with hand-computed boards,
// plus hand-written reset and clear sequences.
module tb_board_commit_judge;
    logic clk;
    logic reset_n;

    board_commit_judge_if bus ();

    board_commit_judge dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic [3:0]  addr;
        logic [1:0]  player;
        logic        ack;
        logic        err;
        logic [17:0] board;
        logic [3:0]  count;
        int          done;
        logic        ready;
        logic [1:0]  result;
        logic        rv;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle_empty(input string tag);
        chk({tag, "_board"},  32'(bus.gBoard), 32'h0);
        chk({tag, "_count"},  32'(bus.move_count), 32'h0);
        chk({tag, "_result"}, 32'(bus.result), 32'h0);
        chk({tag, "_rv"},     32'(bus.result_valid), 32'h0);
        chk({tag, "_ack"},    32'(bus.move_ack), 32'h0);
        chk({tag, "_err"},    32'(bus.move_err), 32'h0);
        chk({tag, "_ready"},  32'(bus.move_ready), 32'h1);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk_idle_empty("clear");
    endtask

    task automatic do_move(input logic [3:0] a, input logic [1:0] p);
        bus.move_valid  = 1'b1;
        bus.move_addr   = a;
        bus.move_player = p;
        tick();
        bus.move_valid  = 1'b0;
    endtask

    function automatic vec_t mk(input logic clr, input logic [3:0] a, input logic [1:0] p,
                                input logic ack, input logic err, input logic [17:0] b,
                                input logic [3:0] c, input int done, input logic rdy,
                                input logic [1:0] res, input logic rv);
        vec_t v;
        v.clr = clr; v.addr = a; v.player = p; v.ack = ack; v.err = err;
        v.board = b; v.count = c; v.done = done; v.ready = rdy; v.result = res; v.rv = rv;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // clr addr player ack err board count done ready result rv
        // Game 1: first move then illegal attempts.
        vecs.push_back(mk(0, 4'd4,  2'b11, 1, 0, 18'h00300, 4'd1, 8, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd9,  2'b11, 0, 1, 18'h00300, 4'd1, 0, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd15, 2'b10, 0, 1, 18'h00300, 4'd1, 0, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd0,  2'b01, 0, 1, 18'h00300, 4'd1, 0, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd0,  2'b00, 0, 1, 18'h00300, 4'd1, 0, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd4,  2'b10, 0, 1, 18'h00300, 4'd1, 0, 1, 2'b00, 0));
        // Game 2: row 0 win for player 11, then a move while OVER is ignored.
        vecs.push_back(mk(1, 4'd0,  2'b11, 1, 0, 18'h00003, 4'd1, 8, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd3,  2'b10, 1, 0, 18'h00083, 4'd2, 8, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd1,  2'b11, 1, 0, 18'h0008F, 4'd3, 8, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd4,  2'b10, 1, 0, 18'h0028F, 4'd4, 8, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd2,  2'b11, 1, 0, 18'h002BF, 4'd5, 1, 0, 2'b11, 1));
        vecs.push_back(mk(0, 4'd5,  2'b10, 0, 0, 18'h002BF, 4'd5, 0, 0, 2'b11, 1));
        // Game 3: anti-diagonal (line 7) win for player 10.
        vecs.push_back(mk(1, 4'd2,  2'b10, 1, 0, 18'h00020, 4'd1, 8, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd0,  2'b11, 1, 0, 18'h00023, 4'd2, 8, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd4,  2'b10, 1, 0, 18'h00223, 4'd3, 8, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd1,  2'b11, 1, 0, 18'h0022F, 4'd4, 8, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd6,  2'b10, 1, 0, 18'h0222F, 4'd5, 8, 0, 2'b10, 1));
        // Game 4: full board tie.
        vecs.push_back(mk(1, 4'd0,  2'b11, 1, 0, 18'h00003, 4'd1, 8, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd1,  2'b10, 1, 0, 18'h0000B, 4'd2, 8, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd2,  2'b11, 1, 0, 18'h0003B, 4'd3, 8, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd3,  2'b11, 1, 0, 18'h000FB, 4'd4, 8, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd4,  2'b10, 1, 0, 18'h002FB, 4'd5, 8, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd5,  2'b10, 1, 0, 18'h00AFB, 4'd6, 8, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd6,  2'b10, 1, 0, 18'h02AFB, 4'd7, 8, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd7,  2'b11, 1, 0, 18'h0EAFB, 4'd8, 8, 1, 2'b00, 0));
        vecs.push_back(mk(0, 4'd8,  2'b11, 1, 0, 18'h3EAFB, 4'd9, 8, 0, 2'b01, 1));

        bus.clear       = 1'b0;
        bus.move_valid  = 1'b0;
        bus.move_addr   = 4'd0;
        bus.move_player = 2'b00;
        reset_n         = 1'b0;
        repeat (2) tick();
        n_vec++;
        chk_idle_empty("por");
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            n_vec++;
            if (vecs[i].clr) do_clear();
            do_move(vecs[i].addr, vecs[i].player);
            chk($sformatf("v%0d_ack", i),   32'(bus.move_ack),   32'(vecs[i].ack));
            chk($sformatf("v%0d_err", i),   32'(bus.move_err),   32'(vecs[i].err));
            chk($sformatf("v%0d_board", i), 32'(bus.gBoard),     32'(vecs[i].board));
            chk($sformatf("v%0d_count", i), 32'(bus.move_count), 32'(vecs[i].count));
            if (vecs[i].done > 0) begin
                repeat (vecs[i].done - 1) tick();
                chk($sformatf("v%0d_busy", i), 32'({bus.move_ready, bus.result_valid}), 32'h0);
                tick();
            end
            chk($sformatf("v%0d_ready", i),  32'(bus.move_ready),   32'(vecs[i].ready));
            chk($sformatf("v%0d_result", i), 32'(bus.result),       32'(vecs[i].result));
            chk($sformatf("v%0d_rv", i),     32'(bus.result_valid), 32'(vecs[i].rv));
        end

        // Clear issued from OVER (tie state).
        n_vec++;
        do_clear();

        // Clear during CHECK, with move_valid also held high.
        n_vec++;
        do_move(4'd4, 2'b11);
        chk("midchk_ack", 32'(bus.move_ack), 32'h1);
        tick();
        bus.clear       = 1'b1;
        bus.move_valid  = 1'b1;
        bus.move_addr   = 4'd0;
        tick();
        bus.clear       = 1'b0;
        bus.move_valid  = 1'b0;
        chk_idle_empty("midchk_clear");

        // Clear wins over a simultaneous legal transfer; the move is dropped.
        n_vec++;
        do_move(4'd4, 2'b11);
        repeat (8) tick();
        chk("prio_setup_ready", 32'(bus.move_ready), 32'h1);
        bus.clear       = 1'b1;
        bus.move_valid  = 1'b1;
        bus.move_addr   = 4'd0;
        bus.move_player = 2'b11;
        tick();
        bus.clear       = 1'b0;
        bus.move_valid  = 1'b0;
        chk_idle_empty("prio");
        tick();
        chk("prio_late_ack", 32'({bus.move_ack, bus.move_err}), 32'h0);
        chk("prio_late_board", 32'(bus.gBoard), 32'h0);

        // Asynchronous reset in the middle of CHECK.
        n_vec++;
        do_move(4'd8, 2'b10);
        chk("rst_setup_board", 32'(bus.gBoard), 32'h20000);
        tick();
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        chk_idle_empty("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Back-to-back: rejected move then immediate legal transfer on the next edge.
        n_vec++;
        do_move(4'd12, 2'b11);
        chk("b2b_err", 32'(bus.move_err), 32'h1);
        do_move(4'd5, 2'b10);
        chk("b2b_ack", 32'({bus.move_ack, bus.move_err}), 32'h2);
        chk("b2b_board", 32'(bus.gBoard), 32'h00800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
